// File: rtl/sram_sync_dp_be_clr.sv
// Simple-dual-port RAM (A: byte-enable read/write, B: read-only) with a clear sweep engine.
// Optional macro SRAM_SYNC_DP_BYPASS_EN: forward same-cycle writes to port B read data.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | normal operation, port A writes accepted
// ST_CLEAR | sweep writes CLEAR_VALUE to mem[cnt], port A writes dropped
module sram_sync_dp_be_clr #(
    parameter int          DATA_WIDTH     = 16,
    parameter int          ADDR_WIDTH     = 10,
    parameter logic [63:0] CLEAR_VALUE    = '0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic [ADDR_WIDTH-1:0]   A_ADDR,
    input  logic [DATA_WIDTH-1:0]   A_DATA,
    input  logic                    A_CEN,
    input  logic                    A_WE,
    input  logic [DATA_WIDTH/8-1:0] A_BE,
    output logic [DATA_WIDTH-1:0]   A_Q,
    input  logic [ADDR_WIDTH-1:0]   B_ADDR,
    input  logic                    B_CEN,
    output logic [DATA_WIDTH-1:0]   B_Q
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] CLR_WORD = DATA_WIDTH'(CLEAR_VALUE);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   a_rd_q;
    logic [DATA_WIDTH-1:0]   b_rd_q;
    logic [DATA_WIDTH-1:0]   b_rd_d;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [NB-1:0]           wr_be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            busy_q  <= CLEAR_ON_RESET;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // One physical write port shared by the sweep and port A; the sweep owns it while clearing.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = A_ADDR;
        wr_data = A_DATA;
        wr_be   = A_BE;
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = CLR_WORD;
            wr_be   = '1;
        end else if (A_CEN && A_WE) begin
            wr_en   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        b_rd_d = mem_q[B_ADDR];
`ifdef SRAM_SYNC_DP_BYPASS_EN
        if (wr_en && (wr_addr == B_ADDR)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    b_rd_d[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
`endif
    end

    // Read-first: the array update above lands after these reads sample the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rd_q <= '0;
            b_rd_q <= '0;
        end else begin
            if (A_CEN) begin
                a_rd_q <= mem_q[A_ADDR];
            end
            if (B_CEN) begin
                b_rd_q <= b_rd_d;
            end
        end
    end

    assign busy = busy_q;
    assign A_Q  = a_rd_q;
    assign B_Q  = b_rd_q;

endmodule

// File: tb/tb_sram_sync_dp_be_clr.sv
// Directed self-checking bench for sram_sync_dp_be_clr (16-bit words, 16-word depth).
module tb_sram_sync_dp_be_clr;

    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic        busy;
    logic [3:0]  A_ADDR;
    logic [15:0] A_DATA;
    logic        A_CEN;
    logic        A_WE;
    logic [1:0]  A_BE;
    logic [15:0] A_Q;
    logic [3:0]  B_ADDR;
    logic        B_CEN;
    logic [15:0] B_Q;

    int n_cmp;
    int n_bad;

`ifdef SRAM_SYNC_DP_BYPASS_EN
    localparam logic [15:0] EXP_B_RDW   = 16'hAAAA;
    localparam logic [15:0] EXP_B_MERGE = 16'hAACD;
`else
    localparam logic [15:0] EXP_B_RDW   = 16'h5555;
    localparam logic [15:0] EXP_B_MERGE = 16'hAAAA;
`endif

    sram_sync_dp_be_clr #(
        .DATA_WIDTH     (16),
        .ADDR_WIDTH     (4),
        .CLEAR_VALUE    (64'h0),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .busy    (busy),
        .A_ADDR  (A_ADDR),
        .A_DATA  (A_DATA),
        .A_CEN   (A_CEN),
        .A_WE    (A_WE),
        .A_BE    (A_BE),
        .A_Q     (A_Q),
        .B_ADDR  (B_ADDR),
        .B_CEN   (B_CEN),
        .B_Q     (B_Q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic a_write(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
        A_CEN = 1'b1; A_WE = 1'b1; A_ADDR = addr; A_DATA = data; A_BE = be;
        @(negedge clk);
        A_CEN = 1'b0; A_WE = 1'b0;
    endtask

    task automatic rd_both(input logic [3:0] addr);
        A_CEN = 1'b1; A_ADDR = addr; B_CEN = 1'b1; B_ADDR = addr;
        @(negedge clk);
        A_CEN = 1'b0; B_CEN = 1'b0;
    endtask

    task automatic count_busy(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cyc;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1)   begin n_bad++; $display("FAIL reset_busy: got %b exp 1", busy); end
        n_cmp++; if (A_Q !== 16'h0)   begin n_bad++; $display("FAIL reset_a_q: got %h exp 0000", A_Q); end
        n_cmp++; if (B_Q !== 16'h0)   begin n_bad++; $display("FAIL reset_b_q: got %h exp 0000", B_Q); end
        rst_n = 1'b1;
        count_busy(cyc);
        n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL reset_sweep_len: got %0d exp 16", cyc); end
        for (int i = 0; i < 16; i++) begin
            B_CEN = 1'b1; B_ADDR = 4'(i);
            @(negedge clk);
            n_cmp++; if (B_Q !== 16'h0) begin n_bad++; $display("FAIL reset_clear_addr%0d: got %h exp 0000", i, B_Q); end
        end
        B_CEN = 1'b0;
    endtask

    task automatic test_byte_enable();
        a_write(4'd3, 16'hBEEF, 2'b11);
        a_write(4'd3, 16'h1234, 2'b01);
        rd_both(4'd3);
        n_cmp++; if (A_Q !== 16'hBE34) begin n_bad++; $display("FAIL be_lo_a_q: got %h exp BE34", A_Q); end
        n_cmp++; if (B_Q !== 16'hBE34) begin n_bad++; $display("FAIL be_lo_b_q: got %h exp BE34", B_Q); end
        a_write(4'd3, 16'hFFFF, 2'b00);
        rd_both(4'd3);
        n_cmp++; if (A_Q !== 16'hBE34) begin n_bad++; $display("FAIL be_none_a_q: got %h exp BE34", A_Q); end
        a_write(4'd3, 16'h5600, 2'b10);
        rd_both(4'd3);
        n_cmp++; if (B_Q !== 16'h5634) begin n_bad++; $display("FAIL be_hi_b_q: got %h exp 5634", B_Q); end
    endtask

    task automatic test_read_during_write();
        a_write(4'd5, 16'h5555, 2'b11);
        A_CEN = 1'b1; A_WE = 1'b1; A_ADDR = 4'd5; A_DATA = 16'hAAAA; A_BE = 2'b11;
        B_CEN = 1'b1; B_ADDR = 4'd5;
        @(negedge clk);
        A_CEN = 1'b0; A_WE = 1'b0; B_CEN = 1'b0;
        n_cmp++; if (A_Q !== 16'h5555)  begin n_bad++; $display("FAIL rdw_a_q: got %h exp 5555", A_Q); end
        n_cmp++; if (B_Q !== EXP_B_RDW) begin n_bad++; $display("FAIL rdw_b_q: got %h exp %h", B_Q, EXP_B_RDW); end
        rd_both(4'd5);
        n_cmp++; if (A_Q !== 16'hAAAA)  begin n_bad++; $display("FAIL rdw_after: got %h exp AAAA", A_Q); end
        A_CEN = 1'b1; A_WE = 1'b1; A_ADDR = 4'd5; A_DATA = 16'h12CD; A_BE = 2'b01;
        B_CEN = 1'b1; B_ADDR = 4'd5;
        @(negedge clk);
        A_CEN = 1'b0; A_WE = 1'b0; B_CEN = 1'b0;
        n_cmp++; if (A_Q !== 16'hAAAA)    begin n_bad++; $display("FAIL rdw_lane_a_q: got %h exp AAAA", A_Q); end
        n_cmp++; if (B_Q !== EXP_B_MERGE) begin n_bad++; $display("FAIL rdw_lane_b_q: got %h exp %h", B_Q, EXP_B_MERGE); end
        rd_both(4'd5);
        n_cmp++; if (B_Q !== 16'hAACD)    begin n_bad++; $display("FAIL rdw_lane_after: got %h exp AACD", B_Q); end
    endtask

    task automatic test_hold();
        a_write(4'd6, 16'h00FF, 2'b11);
        A_CEN = 1'b1; A_ADDR = 4'd6;
        @(negedge clk);
        A_CEN = 1'b0;
        n_cmp++; if (A_Q !== 16'h00FF) begin n_bad++; $display("FAIL hold_read: got %h exp 00FF", A_Q); end
        for (int k = 0; k < 3; k++) begin
            A_ADDR = 4'(3 + 2 * k); A_WE = 1'b1; A_DATA = 16'hFFFF; A_BE = 2'b11;
            @(negedge clk);
            n_cmp++; if (A_Q !== 16'h00FF) begin n_bad++; $display("FAIL hold_cyc%0d: got %h exp 00FF", k, A_Q); end
        end
        A_WE = 1'b0;
        rd_both(4'd6);
        n_cmp++; if (A_Q !== 16'h00FF) begin n_bad++; $display("FAIL hold_no_write: got %h exp 00FF", A_Q); end
    endtask

    task automatic test_busy_write();
        int cyc;
        a_write(4'd12, 16'hC0DE, 2'b11);
        a_write(4'd0, 16'h9999, 2'b11);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 3) begin
                A_CEN = 1'b1; A_WE = 1'b1; A_ADDR = 4'd0; A_DATA = 16'h1111; A_BE = 2'b11;
                B_CEN = 1'b1; B_ADDR = 4'd12;
            end else if (cyc == 4) begin
                n_cmp++; if (B_Q !== 16'hC0DE) begin n_bad++; $display("FAIL busy_partial_read: got %h exp C0DE", B_Q); end
                A_CEN = 1'b0; A_WE = 1'b0; B_CEN = 1'b0;
            end else if (cyc == 5) begin
                clr_req = 1'b1;
            end else if (cyc == 6) begin
                clr_req = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL busy_sweep_len: got %0d exp 16", cyc); end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_no_restart: got %b exp 0", busy); end
        rd_both(4'd0);
        n_cmp++; if (A_Q !== 16'h0) begin n_bad++; $display("FAIL busy_write_dropped: got %h exp 0000", A_Q); end
        rd_both(4'd12);
        n_cmp++; if (B_Q !== 16'h0) begin n_bad++; $display("FAIL busy_addr12_cleared: got %h exp 0000", B_Q); end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        a_write(4'd14, 16'hABCD, 2'b11);
        rd_both(4'd14);
        n_cmp++; if (A_Q !== 16'hABCD) begin n_bad++; $display("FAIL mid_pre_a_q: got %h exp ABCD", A_Q); end
        n_cmp++; if (B_Q !== 16'hABCD) begin n_bad++; $display("FAIL mid_pre_b_q: got %h exp ABCD", B_Q); end
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 8) begin
            cyc++;
            @(negedge clk);
        end
        n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL mid_pre_len: got %0d exp 8", cyc); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1)  begin n_bad++; $display("FAIL mid_rst_busy: got %b exp 1", busy); end
        n_cmp++; if (A_Q !== 16'h0)  begin n_bad++; $display("FAIL mid_rst_a_q: got %h exp 0000", A_Q); end
        n_cmp++; if (B_Q !== 16'h0)  begin n_bad++; $display("FAIL mid_rst_b_q: got %h exp 0000", B_Q); end
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(cyc);
        n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL mid_restart_len: got %0d exp 16", cyc); end
        rd_both(4'd14);
        n_cmp++; if (A_Q !== 16'h0) begin n_bad++; $display("FAIL mid_addr14_cleared: got %h exp 0000", A_Q); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; clr_req = 1'b0;
        A_ADDR = '0; A_DATA = '0; A_CEN = 1'b0; A_WE = 1'b0; A_BE = '0;
        B_ADDR = '0; B_CEN = 1'b0;
        test_reset();
        test_byte_enable();
        test_read_during_write();
        test_hold();
        test_busy_write();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_sync_dp_be_clr.md
Name: sram_sync_dp_be_clr

Overview:
- Parametrised simple-dual-port synchronous RAM: port A read/write with byte-lane enables, port B read-only.
- Built-in clear engine sweeps every word to CLEAR_VALUE after reset or on request.
- Used for video line buffers, sprite RAMs and work RAMs that need a known start state without an init file.
- Infers block RAM; clear engine and output registers are fabric logic.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH.
- CLEAR_VALUE, 0, word written by the clear engine (truncated to DATA_WIDTH).
- CLEAR_ON_RESET, 1, 1 = clear sweep starts automatically on reset release.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr_req  in  1  single-cycle pulse requests a clear sweep
- busy  out  1  high while the clear sweep runs
- A_ADDR  in  ADDR_WIDTH  port A address
- A_DATA  in  DATA_WIDTH  port A write data
- A_CEN  in  1  port A enable
- A_WE  in  1  port A write strobe, qualified by A_CEN
- A_BE  in  DATA_WIDTH/8  byte-lane enables; bit i covers A_DATA[8i+7:8i]
- A_Q  out  DATA_WIDTH  port A registered read data
- B_ADDR  in  ADDR_WIDTH  port B address
- B_CEN  in  1  port B enable
- B_Q  out  DATA_WIDTH  port B registered read data

Behaviour:
- Interface: one clock, clk; reset is rst_n, asynchronous and active-low.
- Reset values:
  - A_Q = 0, B_Q = 0.
  - Clear counter = 0.
  - State = CLEAR and busy = 1 if CLEAR_ON_RESET = 1; otherwise state = IDLE and busy = 0.
  - Memory array is not reset.
- Read latency:
  - 1 cycle on both ports.
  - A_Q/B_Q update only on cycles where their CEN = 1; otherwise they hold.
- Port A write:
  - Occurs when A_CEN & A_WE & state == IDLE.
  - Only lanes with A_BE[i] = 1 are updated.
  - A_BE = 0 is a no-op write.
- Port A read-during-write, same port: read-first. A_Q returns the pre-write word.
- Port B reading the address port A writes in the same cycle: returns the old word (unless the optional feature is enabled).
- FSM states:
  - IDLE -> CLEAR when clr_req = 1; busy rises the following cycle.
  - CLEAR: writes CLEAR_VALUE to mem[cnt] each cycle and increments cnt.
  - CLEAR -> IDLE after writing address 2**ADDR_WIDTH-1; cnt wraps to 0, busy falls on that same edge.
  - Sweep length: exactly 2**ADDR_WIDTH cycles with busy = 1.
- During CLEAR:
  - Port A writes are dropped; no queuing.
  - Reads on both ports still execute and return current array contents (partially cleared).
  - clr_req is ignored; the sweep does not restart.
- Reset asserted mid-sweep: cnt returns to 0. With CLEAR_ON_RESET = 1 the sweep restarts from 0; otherwise IDLE with array contents undefined.
- Address arithmetic: cnt is ADDR_WIDTH bits, unsigned, natural wrap. No out-of-range addresses exist.

Optional Feature:
- Macro: SRAM_SYNC_DP_BYPASS_EN.
- Defined:
  - Port B write-through forwarding. When B_CEN = 1 and B_ADDR matches an active write address (port A write or clear-engine write) in the same cycle, B_Q takes the new word.
  - For a port A write, B_Q is per-lane merged: lanes with A_BE = 1 come from A_DATA, the others from the old word.
  - For a clear write, B_Q = CLEAR_VALUE.
- Undefined: no forwarding comparator; B_Q returns the old word as described above.

Test Plan:
- Reset release with CLEAR_ON_RESET = 1, ADDR_WIDTH = 4 -> busy = 1 for exactly 16 cycles; then reading all 16 addresses on B returns 0x0000.
- Write 0xBEEF to addr 3 with A_BE = 2'b11, then A_BE = 2'b01 with 0x1234 -> next read of addr 3 returns 0xBE34 on both A_Q and B_Q, 1-cycle latency.
- Same-cycle A write of 0xAAAA to addr 5 (old 0x5555) plus B read of addr 5 -> B_Q = 0x5555 without the macro, 0xAAAA with SRAM_SYNC_DP_BYPASS_EN. A_Q = 0x5555 in both builds.
- Port A write of 0x1111 issued during busy, then pulse clr_req at cycle 5 of the sweep -> write lost; sweep still completes at 16 cycles with no restart.
- rst_n asserted at cycle 8 of the sweep, released 2 cycles later -> busy stays 1; a full 16-cycle sweep restarts from address 0.
- A_CEN = 0 for 3 cycles after a read of 0x00FF -> A_Q holds 0x00FF regardless of A_ADDR changes.
